// File: rtl/mac_tap_sequencer.sv
// Tap sequencer for the FP32 MAC datapath: clear, per-tap LD_coeff/LD_signal, drain, done.
// Optional `abort` input is compiled in when MAC_SEQ_ABORT_EN is defined.
module mac_tap_sequencer #(
    parameter int TAP_W   = 8,
    parameter int ADDR_W  = 8,
    parameter int MAC_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MAC_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic [TAP_W-1:0]  num_taps,
    output logic [ADDR_W-1:0] coeff_addr,
    output logic [ADDR_W-1:0] signal_addr,
    output logic              LD_coeff,
    output logic              LD_signal,
    output logic              rstc_n,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LD_C  = 3'd2,
        LD_S  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state, state_next;
    logic [TAP_W-1:0]   idx, idx_next;
    logic [TAP_W-1:0]   n_reg, n_next;
    logic [CNT_W-1:0]   cnt, cnt_next;

    // Command handshake: start is a strobe honoured only in IDLE (busy=0);
    // while busy it is dropped, never queued. num_taps is captured on acceptance.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        n_next     = n_reg;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    n_next     = num_taps;
                    idx_next   = '0;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                idx_next   = '0;
                state_next = (n_reg != '0) ? LD_C : DONE;
            end
            LD_C: state_next = LD_S;
            LD_S: begin
                if (idx == n_reg - TAP_W'(1)) begin
                    cnt_next   = '0;
                    state_next = DRAIN;
                end else begin
                    idx_next   = idx + TAP_W'(1);
                    state_next = LD_C;
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(MAC_LAT - 1)) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
`ifdef MAC_SEQ_ABORT_EN
        // Abort wins over every transition but leaves the address where it is.
        if (abort && state != IDLE) begin
            state_next = IDLE;
            idx_next   = idx;
        end
`endif
    end

    // Strobes are registered decodes of the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            n_reg     <= '0;
            cnt       <= '0;
            LD_coeff  <= 1'b0;
            LD_signal <= 1'b0;
            rstc_n    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            n_reg     <= n_next;
            cnt       <= cnt_next;
            LD_coeff  <= (state_next == LD_C);
            LD_signal <= (state_next == LD_S);
            rstc_n    <= (state_next != CLEAR);
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
        end
    end

    assign coeff_addr  = ADDR_W'(idx);
    assign signal_addr = ADDR_W'(idx);

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Self-checking bench for mac_tap_sequencer: expected per-cycle output vectors are
// derived from the cycle-level latency formulas and compared against the DUT.
module tb_mac_tap_sequencer;

    localparam int TAP_W   = 8;
    localparam int ADDR_W  = 8;
    localparam int MAC_LAT = 3;
    localparam int W       = 5 + ADDR_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [TAP_W-1:0]  num_taps;
    logic [ADDR_W-1:0] coeff_addr;
    logic [ADDR_W-1:0] signal_addr;
    logic              LD_coeff;
    logic              LD_signal;
    logic              rstc_n;
    logic              busy;
    logic              done;
`ifdef MAC_SEQ_ABORT_EN
    logic              abort;
`endif

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;

    mac_tap_sequencer #(.TAP_W(TAP_W), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MAC_SEQ_ABORT_EN
        .abort       (abort),
`endif
        .start       (start),
        .num_taps    (num_taps),
        .coeff_addr  (coeff_addr),
        .signal_addr (signal_addr),
        .LD_coeff    (LD_coeff),
        .LD_signal   (LD_signal),
        .rstc_n      (rstc_n),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h (busy,done,ldc,lds,rstc_n,addr)", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] observed();
        if (coeff_addr !== signal_addr)
            return '1;
        return {busy, done, LD_coeff, LD_signal, rstc_n, coeff_addr};
    endfunction

    function automatic logic [W-1:0] pack(input logic b, input logic d, input logic lc,
                                          input logic ls, input logic rc, input int addr);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(addr);
        return {b, d, lc, ls, rc, a};
    endfunction

    // Cycle c counts from the acceptance edge: CLEAR=1, LD_C(k)=2+2k, LD_S(k)=3+2k.
    function automatic logic [W-1:0] exp_vec(input int c, input int n);
        int t;
        int last;
        t    = (n == 0) ? 2 : 2 * n + 2 + MAC_LAT;
        last = (n == 0) ? 0 : n - 1;
        if (c == 1)
            return pack(1, 0, 0, 0, 0, 0);
        if (c <= 2 * n + 1)
            return pack(1, 0, (c % 2) == 0, (c % 2) == 1, 1, (c - 2) / 2);
        if (c <= t)
            return pack(1, c == t, 0, 0, 1, last);
        return pack(0, 0, 0, 0, 1, last);
    endfunction

    task automatic step(input string tag);
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, observed(), e);
        end
    endtask

    // Runs one command of n taps; hold keeps start high for back-to-back acceptance.
    task automatic run_cmd(input int n, input bit hold);
        int t;
        t = (n == 0) ? 2 : 2 * n + 2 + MAC_LAT;
        start    = 1'b1;
        num_taps = TAP_W'(n);
        for (int c = 1; c <= t + 1; c++) begin
            exp_q.push_back(exp_vec(c, n));
            step($sformatf("n%0d_c%0d", n, c));
            if (!hold) start = 1'b0;
            num_taps = TAP_W'($urandom_range(0, 255));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        num_taps = '0;
`ifdef MAC_SEQ_ABORT_EN
        abort    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", observed(), pack(0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        exp_q.push_back(pack(0, 0, 0, 0, 1, 0));
        step("first_idle");

        run_cmd(3, 1'b0);
        run_cmd(0, 1'b0);
        run_cmd(3, 1'b1);
        run_cmd(3, 1'b0);
        run_cmd(1, 1'b0);
        for (int i = 0; i < 3; i++)
            run_cmd($urandom_range(2, 6), 1'b0);
        run_cmd(255, 1'b0);

        start    = 1'b1;
        num_taps = 8'd3;
        for (int c = 1; c <= 5; c++) begin
            exp_q.push_back(exp_vec(c, 3));
            step($sformatf("rstrun_c%0d", c));
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_eq("rst_async", observed(), pack(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check_eq("rst_held", observed(), pack(0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            exp_q.push_back(pack(0, 0, 0, 0, 1, 0));
            step($sformatf("post_rst_%0d", c));
        end
        run_cmd(2, 1'b0);

`ifdef MAC_SEQ_ABORT_EN
        start    = 1'b1;
        num_taps = 8'd3;
        for (int c = 1; c <= 8; c++) begin
            exp_q.push_back(exp_vec(c, 3));
            step($sformatf("abrun_c%0d", c));
            start = 1'b0;
        end
        abort = 1'b1;
        exp_q.push_back(pack(0, 0, 0, 0, 1, 2));
        step("abort_idle");
        abort = 1'b0;
        for (int c = 0; c < 6; c++) begin
            exp_q.push_back(pack(0, 0, 0, 0, 1, 2));
            step($sformatf("abort_quiet_%0d", c));
        end
        run_cmd(3, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
